// File: rtl/csr_router_pkg.sv
// Shared types and constants for the CSR access router.
// XLEN falls back to 32 when the build does not define it.
`ifndef XLEN
`define XLEN 32
`endif

package csr_router_pkg;
  localparam int CSR_ADDR_W = 12;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_NO_MATCH = 3'd1,
    ERR_PRIV     = 3'd2,
    ERR_RO_WRITE = 3'd3,
    ERR_TIMEOUT  = 3'd4
  } csr_err_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } csr_rt_state_e;
endpackage

// File: rtl/csr_router_if.sv
// Bundle of the core-side request/response bus and the per-channel CSR bus.
// The slave modport is the router view; the master modport is the surrounding system.
interface csr_router_if
  import csr_router_pkg::*;
#(
  parameter int XLEN = `XLEN,
  parameter int NCH  = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_rd;
  logic                  req_wr;
  logic [CSR_ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]       req_wdata;
  logic [1:0]            req_priv;
  logic                  rsp_valid;
  logic [XLEN-1:0]       rsp_rdata;
  logic [2:0]            rsp_err;
  logic [NCH-1:0]        ch_req;
  logic                  ch_wr;
  logic [CSR_ADDR_W-1:0] ch_addr;
  logic [XLEN-1:0]       ch_wdata;
  logic [NCH-1:0]        ch_ack;
  logic [NCH*XLEN-1:0]   ch_rdata;

  modport slave (
    input  req_valid, req_rd, req_wr, req_addr, req_wdata, req_priv, ch_ack, ch_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, ch_req, ch_wr, ch_addr, ch_wdata
  );

  modport master (
    output req_valid, req_rd, req_wr, req_addr, req_wdata, req_priv, ch_ack, ch_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, ch_req, ch_wr, ch_addr, ch_wdata
  );
endinterface

// File: rtl/csr_router_addr_match.sv
// Combinational window decoder: every channel compares (addr & mask) against its base,
// and the lowest-indexed hit is kept so overlapping windows resolve deterministically.
module csr_addr_match
  import csr_router_pkg::*;
#(
  parameter int                          NCH     = 4,
  parameter logic [NCH*CSR_ADDR_W-1:0]   CH_BASE = '0,
  parameter logic [NCH*CSR_ADDR_W-1:0]   CH_MASK = '0
) (
  input  logic [CSR_ADDR_W-1:0] i_addr,
  output logic [NCH-1:0]        o_sel,
  output logic                  o_hit
);
  logic [NCH-1:0] w_raw;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_win
    assign w_raw[gi] = ((i_addr & CH_MASK[CSR_ADDR_W*gi +: CSR_ADDR_W])
                        == CH_BASE[CSR_ADDR_W*gi +: CSR_ADDR_W]);
  end

  // Two's-complement trick isolates the lowest set bit.
  assign o_sel = w_raw & (~w_raw + NCH'(1));
  assign o_hit = |w_raw;
endmodule

// File: rtl/csr_router.sv
// CSR access router: decodes the address, checks privilege/read-only rules, forwards
// the access to one channel over a req/ack handshake with timeout, returns one response.
module csr_router
  import csr_router_pkg::*;
#(
  parameter int                        XLEN    = `XLEN,
  parameter int                        NCH     = 4,
  parameter logic [NCH*CSR_ADDR_W-1:0] CH_BASE = {12'h300, 12'hB00, 12'h7A0, 12'h3A0},
  parameter logic [NCH*CSR_ADDR_W-1:0] CH_MASK = {12'hF00, 12'hF00, 12'hFF0, 12'hFE0},
  parameter int                        TMO_CYC = 16
) (
  input logic       clk,
  input logic       rst,
  csr_router_if.slave bus
);
  localparam int CNT_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (TMO_CYC > 0) ? CNT_W'(TMO_CYC - 1) : '0;

  csr_rt_state_e         r_state,     w_state_next;
  logic                  r_rsp_valid, w_rsp_valid_next;
  logic [XLEN-1:0]       r_rsp_rdata, w_rsp_rdata_next;
  csr_err_e              r_rsp_err,   w_rsp_err_next;
  logic [NCH-1:0]        r_ch_req,    w_ch_req_next;
  logic                  r_ch_wr,     w_ch_wr_next;
  logic [CSR_ADDR_W-1:0] r_ch_addr,   w_ch_addr_next;
  logic [XLEN-1:0]       r_ch_wdata,  w_ch_wdata_next;
  logic                  r_rd,        w_rd_next;
  logic [CNT_W-1:0]      r_cnt,       w_cnt_next;

  logic [NCH-1:0]  w_sel;
  logic            w_hit;
  csr_err_e        w_cap_err;
  logic            w_ack_sel;
  logic [XLEN-1:0] w_rd_terms [NCH];
  logic [XLEN-1:0] w_rd_mux;

  csr_addr_match #(
    .NCH     (NCH),
    .CH_BASE (CH_BASE),
    .CH_MASK (CH_MASK)
  ) u_match (
    .i_addr (bus.req_addr),
    .o_sel  (w_sel),
    .o_hit  (w_hit)
  );

  // r_ch_req doubles as the latched one-hot channel select while in ACCESS.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_rd
    assign w_rd_terms[gi] = r_ch_req[gi] ? bus.ch_rdata[XLEN*gi +: XLEN] : '0;
  end

  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NCH; i++) begin
      w_rd_mux = w_rd_mux | w_rd_terms[i];
    end
  end

  assign w_ack_sel = |(bus.ch_ack & r_ch_req);

  always_comb begin
    w_cap_err = ERR_OK;
    if (bus.req_addr[9:8] > bus.req_priv) begin
      w_cap_err = ERR_PRIV;
    end else if (bus.req_wr && (bus.req_addr[11:10] == 2'b11)) begin
      w_cap_err = ERR_RO_WRITE;
    end else if (!w_hit) begin
      w_cap_err = ERR_NO_MATCH;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    w_ch_req_next    = r_ch_req;
    w_ch_wr_next     = r_ch_wr;
    w_ch_addr_next   = r_ch_addr;
    w_ch_wdata_next  = r_ch_wdata;
    w_rd_next        = r_rd;
    w_cnt_next       = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && (bus.req_rd || bus.req_wr)) begin
          w_ch_addr_next  = bus.req_addr;
          w_ch_wdata_next = bus.req_wdata;
          w_rd_next       = bus.req_rd;
          w_ch_wr_next    = bus.req_wr;
          if (w_cap_err != ERR_OK) begin
            w_rsp_valid_next = 1'b1;
            w_rsp_rdata_next = '0;
            w_rsp_err_next   = w_cap_err;
            w_state_next     = ST_RESP;
          end else begin
            w_ch_req_next = w_sel;
            w_cnt_next    = '0;
            w_state_next  = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // Ack is tested first so an ack on the final timeout cycle still completes.
        if (w_ack_sel) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = r_rd ? w_rd_mux : '0;
          w_rsp_err_next   = ERR_OK;
          w_ch_req_next    = '0;
          w_state_next     = ST_RESP;
        end else if ((TMO_CYC != 0) && (r_cnt == TMO_LAST)) begin
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = ERR_TIMEOUT;
          w_ch_req_next    = '0;
          w_state_next     = ST_RESP;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
      r_ch_req    <= '0;
      r_ch_wr     <= 1'b0;
      r_ch_addr   <= '0;
      r_ch_wdata  <= '0;
      r_rd        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
      r_ch_req    <= w_ch_req_next;
      r_ch_wr     <= w_ch_wr_next;
      r_ch_addr   <= w_ch_addr_next;
      r_ch_wdata  <= w_ch_wdata_next;
      r_rd        <= w_rd_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.ch_req    = r_ch_req;
  assign bus.ch_wr     = r_ch_wr;
  assign bus.ch_addr   = r_ch_addr;
  assign bus.ch_wdata  = r_ch_wdata;
endmodule

// File: tb/tb_csr_router.sv
// Scenario bench for csr_router: expected responses are queued at acceptance and
// checked (data, error code, arrival cycle) by a monitor when rsp_valid fires.
module tb_csr_router;
  import csr_router_pkg::*;

  localparam int XL = 32;
  localparam int NC = 4;

  typedef struct {
    logic [XL-1:0] rdata;
    logic [2:0]    err;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  csr_router_if #(.XLEN(XL), .NCH(NC)) bus ();

  csr_router #(
    .XLEN    (XL),
    .NCH     (NC),
    .CH_BASE ({12'h300, 12'hB00, 12'h7A0, 12'h3A0}),
    .CH_MASK ({12'hF00, 12'hF00, 12'hFF0, 12'hFE0}),
    .TMO_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got rdata=%h err=%0d at cyc %0d, required no response",
                 bus.rsp_rdata, bus.rsp_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL rsp: got rdata=%h err=%0d cyc=%0d, required rdata=%h err=%0d cyc=%0d",
                   bus.rsp_rdata, bus.rsp_err, cyc, e.rdata, e.err, e.cyc);
        end else begin
          $display("rsp ok: rdata=%h err=%0d cyc=%0d", bus.rsp_rdata, bus.rsp_err, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  task automatic issue(input logic rd, input logic wr, input logic [11:0] addr,
                       input logic [XL-1:0] wdata, input logic [1:0] priv,
                       input bit exp_rsp, input logic [XL-1:0] exp_rdata,
                       input logic [2:0] exp_err, input int exp_lat);
    int w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_priv  = priv;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_wait: req_ready stuck at %b, required 1", bus.req_ready);
    end else if (exp_rsp) begin
      sb.push_back('{rdata: exp_rdata, err: exp_err, cyc: cyc + exp_lat});
    end
    $display("req: rd=%b wr=%b addr=%h wdata=%h priv=%0d cyc=%0d", rd, wr, addr, wdata, priv, cyc);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
  endtask

  // gap 0 = ack sampled on the first ACCESS edge.
  task automatic ack_after(input int ch, input int gap);
    repeat (gap) @(posedge clk);
    @(negedge clk);
    bus.ch_ack = NC'(1 << ch);
    @(posedge clk);
    #1;
    bus.ch_ack = '0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_priv  = PRIV_M;
    bus.ch_ack    = '0;
    bus.ch_rdata  = {32'h3333_0003, 32'h2222_0002, 32'hBEEF_0001, 32'h0000_DEAD};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks += 5;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    if (bus.rsp_rdata !== '0 || bus.rsp_err !== 3'd0) begin
      n_fail++; $display("FAIL reset_rsp: got rdata=%h err=%0d required 0/0", bus.rsp_rdata, bus.rsp_err);
    end
    if (bus.ch_req !== '0 || bus.ch_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_ch_req: got req=%b wr=%b required 0/0", bus.ch_req, bus.ch_wr);
    end
    if (bus.ch_addr !== '0 || bus.ch_wdata !== '0) begin
      n_fail++; $display("FAIL reset_ch_data: got addr=%h wdata=%h required 0/0", bus.ch_addr, bus.ch_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_read_overlap();
    issue(1'b1, 1'b0, 12'h3A0, '0, PRIV_M, 1'b1, 32'h0000_DEAD, 3'd0, 3);
    n_checks += 2;
    if (bus.ch_req !== 4'b0001) begin n_fail++; $display("FAIL overlap_sel: got %b required 0001", bus.ch_req); end
    if (bus.ch_wr !== 1'b0 || bus.ch_addr !== 12'h3A0) begin
      n_fail++; $display("FAIL overlap_qual: got wr=%b addr=%h required 0/3a0", bus.ch_wr, bus.ch_addr);
    end
    ack_after(0, 1);
    wait_drain();
  endtask

  task automatic test_errors();
    issue(1'b0, 1'b1, 12'hF11, 32'h1, PRIV_M, 1'b1, '0, 3'd3, 1);
    n_checks += 2;
    if (bus.ch_req !== '0) begin n_fail++; $display("FAIL ro_no_req: got %b required 0", bus.ch_req); end
    if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL resp_ready: got %b required 0", bus.req_ready); end
    issue(1'b1, 1'b0, 12'h300, '0, PRIV_S, 1'b1, '0, 3'd2, 1);
    n_checks++;
    if (bus.ch_req !== '0) begin n_fail++; $display("FAIL priv_no_req: got %b required 0", bus.ch_req); end
    issue(1'b1, 1'b0, 12'h5C0, '0, PRIV_M, 1'b1, '0, 3'd1, 1);
    issue(1'b0, 1'b1, 12'hF11, 32'h2, PRIV_S, 1'b1, '0, 3'd2, 1);
    issue(1'b1, 1'b0, 12'h0A0, '0, PRIV_U, 1'b1, '0, 3'd1, 1);
    wait_drain();
  endtask

  task automatic test_timeout();
    int held = 0;
    int bad = 0;
    issue(1'b0, 1'b1, 12'h305, 32'h80, PRIV_M, 1'b1, '0, 3'd4, 17);
    n_checks++;
    if (bus.ch_wr !== 1'b1 || bus.ch_addr !== 12'h305 || bus.ch_wdata !== 32'h80) begin
      n_fail++; $display("FAIL tmo_qual: got wr=%b addr=%h wdata=%h required 1/305/80",
                         bus.ch_wr, bus.ch_addr, bus.ch_wdata);
    end
    for (int i = 0; i < 24; i++) begin
      if (bus.ch_req === 4'b1000) held++;
      else if (bus.ch_req !== '0) bad++;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (held != 16 || bad != 0) begin
      n_fail++; $display("FAIL tmo_held: got %0d cycles (%0d bad), required 16 (0 bad)", held, bad);
    end
    wait_drain();
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    bus.ch_ack = 4'b0100;
    @(negedge clk);
    bus.ch_ack = '0;
    issue(1'b1, 1'b0, 12'hB00, '0, PRIV_M, 1'b1, 32'h2222_0002, 3'd0, 17);
    n_checks++;
    if (bus.ch_req !== 4'b0100) begin n_fail++; $display("FAIL spur_sel: got %b required 0100", bus.ch_req); end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      bus.ch_ack = (j == 16) ? 4'b0100 : ((j % 2 == 1) ? 4'b0010 : 4'b1001);
      @(posedge clk);
    end
    #1;
    bus.ch_ack = '0;
    wait_drain();
  endtask

  task automatic test_rst_in_access();
    issue(1'b1, 1'b0, 12'h300, '0, PRIV_M, 1'b0, '0, 3'd0, 0);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.ch_req !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_req: got %b required 1000", bus.ch_req); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (bus.ch_req !== '0) begin n_fail++; $display("FAIL rst_ch_req: got %b required 0", bus.ch_req); end
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp: got %b required 0", bus.rsp_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", bus.req_ready); end
    issue(1'b1, 1'b0, 12'h7A5, '0, PRIV_M, 1'b1, 32'hBEEF_0001, 3'd0, 2);
    n_checks++;
    if (bus.ch_req !== 4'b0010) begin n_fail++; $display("FAIL post_rst_sel: got %b required 0010", bus.ch_req); end
    ack_after(1, 0);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 12'h3A4, 32'h55, PRIV_M, 1'b1, '0, 3'd0, 2);
    ack_after(0, 0);
    issue(1'b1, 1'b1, 12'h7A1, 32'hA5A5_0000, PRIV_M, 1'b1, 32'hBEEF_0001, 3'd0, 2);
    n_checks++;
    if (bus.ch_req !== 4'b0010 || bus.ch_wr !== 1'b1 || bus.ch_wdata !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL swap_qual: got req=%b wr=%b wdata=%h required 0010/1/a5a50000",
                         bus.ch_req, bus.ch_wr, bus.ch_wdata);
    end
    ack_after(1, 0);
    issue(1'b0, 1'b1, 12'hC00, 32'h3, PRIV_M, 1'b1, '0, 3'd3, 1);
    issue(1'b1, 1'b0, 12'h5C0, '0, PRIV_M, 1'b1, '0, 3'd1, 1);
    wait_drain();
  endtask

  task automatic test_dropped();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 12'h3A0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.ch_req !== '0) begin
      n_fail++; $display("FAIL dropped: got ready=%b req=%b required 1/0", bus.req_ready, bus.ch_req);
    end
    repeat (3) @(negedge clk);
    $display("dropped request: no response expected");
  endtask

  initial begin
    test_reset();
    test_read_overlap();
    test_errors();
    test_timeout();
    test_spurious_ack();
    test_rst_in_access();
    test_back_to_back();
    test_dropped();
    wait_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_router.md
Name: csr_router

Overview:
- Parametrised CSR access router between the core's CSR stage and NCH CSR-owning units (PMP, debug, perf counters, machine trap, ...).
- Decodes each 12-bit CSR address against per-channel base/mask windows; lowest channel index wins on overlap.
- Forwards the access over a req/ack handshake with a timeout, and enforces privilege and read-only rules.
- Returns a single registered response with an error code.

Parameters:
- XLEN, `XLEN: CSR data width.
- NCH, 4: number of target channels (1..16).
- CH_BASE, {12'h300,12'hB00,12'h7A0,12'h3A0}: packed NCH*12; channel i base at [12i+11:12i].
- CH_MASK, {12'hF00,12'hF00,12'hFF0,12'hFE0}: packed NCH*12. Channel i matches when (addr & mask_i) == base_i.
- TMO_CYC, 16: cycles to wait for ch_ack before a TIMEOUT error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  access request
- req_ready  out  1  router idle; accepts the request this cycle
- req_rd  in  1  read access
- req_wr  in  1  write access (rd and wr both set = swap)
- req_addr  in  12  CSR address
- req_wdata  in  XLEN  write data
- req_priv  in  2  current privilege (0=U, 1=S, 3=M)
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  XLEN  read data; 0 on error or write-only access
- rsp_err  out  3  0 OK, 1 NO_MATCH, 2 PRIV, 3 RO_WRITE, 4 TIMEOUT
- ch_req  out  NCH  one-hot channel strobe, held until ack
- ch_wr  out  1  write qualifier for ch_req
- ch_addr  out  12  latched address
- ch_wdata  out  XLEN  latched write data
- ch_ack  in  NCH  per-channel completion
- ch_rdata  in  NCH*XLEN  per-channel read data; channel i at [XLEN*i+XLEN-1:XLEN*i]

Behaviour:
- Reset values (clocked synchronously while rst=1): state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, ch_req 0, ch_wr 0, ch_addr 0, ch_wdata 0, timeout counter 0.
- req_ready = (state == IDLE), combinational.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, request capture:
  - Capture occurs when req_valid && (req_rd || req_wr). The router latches addr, wdata, rd and wr, and decodes.
  - req_valid with neither rd nor wr is dropped: no response, stays IDLE.
- IDLE, error checks, in priority order:
  - PRIV when addr[9:8] > req_priv.
  - RO_WRITE when wr && addr[11:10] == 2'b11.
  - NO_MATCH when no window hits.
  - On any error, go to RESP. No ch_req is driven.
- IDLE, no error: set ch_req[sel], ch_wr = wr and timeout counter = 0, then go to ACCESS.
- ACCESS:
  - ch_req, ch_wr, ch_addr and ch_wdata are held stable.
  - On ch_ack[sel]: capture ch_rdata[sel] if rd (else 0), err = OK, clear ch_req, go to RESP.
  - Otherwise the counter increments. When the counter == TMO_CYC-1 (TMO_CYC != 0), set err = TIMEOUT, rdata = 0, clear ch_req, go to RESP.
  - An ack in the same cycle as the timeout: the ack wins.
- RESP: rsp_valid = 1 for exactly one cycle with rsp_rdata and rsp_err, then go to IDLE. The response cannot be back-pressured.
- Latency:
  - Error path: rsp_valid 1 cycle after acceptance.
  - Normal path: ch_req 1 cycle after acceptance; with a same-cycle ack, rsp_valid 2 cycles after acceptance.
- Acks from non-selected channels, and any ack outside ACCESS, are ignored.
- rst asserted in any state returns all registers to reset values next edge; an in-flight access is abandoned with no response.
- Timeout counter width: $clog2(TMO_CYC+1), minimum 1.

Decomposition:
- csr_router_pkg:
  - csr_err_e (3-bit error enum)
  - csr_rt_state_e (IDLE/ACCESS/RESP)
  - CSR_ADDR_W = 12
  - PRIV_U/S/M constants
- Sub-module csr_addr_match: combinational priority decoder. Inputs: addr, CH_BASE, CH_MASK. Outputs: one-hot sel[NCH], hit.

Test Plan:
- Read 0x3A0, priv 3; ch0 acks 1 cycle after ch_req with 0xDEAD -> ch_req=4'b0001 (ch0 wins over the ch3 window), rsp_rdata=0xDEAD, rsp_err=0, rsp_valid 3 cycles after acceptance.
- Write 0xF11, priv 3 -> no ch_req, rsp_valid next cycle, rsp_err=3, rsp_rdata=0.
- Read 0x300, priv 1 -> rsp_err=2, no ch_req; read 0x5C0, priv 3 -> rsp_err=1.
- Write 0x305 = 0x80; ch3 never acks -> ch_req=4'b1000 held 16 cycles, then cleared; rsp_err=4.
- Read 0xB00; ch1 and ch2 ack spuriously, ch2 acks on cycle 16 (timeout cycle) -> spurious ignored, rsp_err=0, rdata from ch2.
- rst asserted 2 cycles into ACCESS -> ch_req=0 next edge, no rsp_valid, req_ready=1 after rst drops; next access completes normally.
